// File: rtl/next_hop_selector.sv
// next_hop_selector: scans the neighbour table one entry per clock and picks
// the cheapest eligible next hop toward a sink, preferring neighbours outside
// the own cluster on cost ties. Sink / non-forwarding nodes skip the scan.
module next_hop_selector #(
  parameter int NUM_NEIGHBORS = 10,
  parameter int ID_W          = 5,
  parameter int COST_W        = 8,
  parameter int IDX_W         = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            iam_sink,
  input  logic                            iam_forwarding,
  input  logic [ID_W-1:0]                 my_node_id,
  input  logic [ID_W-1:0]                 my_cluster_id,
  input  logic [NUM_NEIGHBORS*ID_W-1:0]   neighbor_ids,
  input  logic [NUM_NEIGHBORS*ID_W-1:0]   neighbor_clusters,
  input  logic [NUM_NEIGHBORS*COST_W-1:0] neighbor_costs,
  input  logic [NUM_NEIGHBORS-1:0]        neighbor_valid,
  output logic                            busy,
  output logic                            done,
  output logic                            found,
  output logic                            local_sink,
  output logic [ID_W-1:0]                 next_hop_id,
  output logic [COST_W-1:0]               best_cost,
  output logic [IDX_W-1:0]                best_index
);

  localparam int TBL_SIZE = 1 << IDX_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [COST_W-1:0] COST_INF = '1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_NEIGHBORS - 1);

  // Unpacked views of the flattened tables, padded to the full index range
  // so that any idx value selects a defined (invalid) entry.
  logic [ID_W-1:0]   id_tbl      [TBL_SIZE];
  logic [ID_W-1:0]   cluster_tbl [TBL_SIZE];
  logic [COST_W-1:0] cost_tbl    [TBL_SIZE];
  logic              valid_tbl   [TBL_SIZE];

  genvar gi;
  generate
    for (gi = 0; gi < TBL_SIZE; gi++) begin : g_tbl
      if (gi < NUM_NEIGHBORS) begin : g_used
        assign id_tbl[gi]      = neighbor_ids[ID_W*gi +: ID_W];
        assign cluster_tbl[gi] = neighbor_clusters[ID_W*gi +: ID_W];
        assign cost_tbl[gi]    = neighbor_costs[COST_W*gi +: COST_W];
        assign valid_tbl[gi]   = neighbor_valid[gi];
      end else begin : g_pad
        assign id_tbl[gi]      = '0;
        assign cluster_tbl[gi] = '0;
        assign cost_tbl[gi]    = '0;
        assign valid_tbl[gi]   = 1'b0;
      end
    end
  endgenerate

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              bypass_q, bypass_d;
  logic              found_q, found_d;
  logic              local_sink_q, local_sink_d;
  logic [ID_W-1:0]   next_hop_id_q, next_hop_id_d;
  logic [COST_W-1:0] best_cost_q, best_cost_d;
  logic [IDX_W-1:0]  best_index_q, best_index_d;
  logic [ID_W-1:0]   best_cluster_q, best_cluster_d;

  logic [ID_W-1:0]   cur_id;
  logic [ID_W-1:0]   cur_cluster;
  logic [COST_W-1:0] cur_cost;
  logic              cur_valid;
  logic              eligible;
  logic [COST_W-1:0] cand_total;
  logic              better;

  // Evaluate the entry currently addressed by the scan index.
  always_comb begin
    cur_id      = id_tbl[idx_q];
    cur_cluster = cluster_tbl[idx_q];
    cur_cost    = cost_tbl[idx_q];
    cur_valid   = valid_tbl[idx_q];
    eligible    = cur_valid && (cur_id != my_node_id) && (cur_cost != COST_INF);
    // Cannot wrap: an all-ones cost is never eligible.
    cand_total  = cur_cost + COST_W'(1);
    better      = !found_q
               || (cand_total < best_cost_q)
               || ((cand_total == best_cost_q)
                   && (cur_cluster != my_cluster_id)
                   && (best_cluster_q == my_cluster_id));
  end

  // Next-state and result-update logic for the IDLE/SCAN/DONE controller.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    bypass_d       = bypass_q;
    found_d        = found_q;
    local_sink_d   = local_sink_q;
    next_hop_id_d  = next_hop_id_q;
    best_cost_d    = best_cost_q;
    best_index_d   = best_index_q;
    best_cluster_d = best_cluster_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          found_d        = 1'b0;
          local_sink_d   = iam_sink;
          best_cost_d    = COST_INF;
          next_hop_id_d  = '0;
          best_index_d   = '0;
          best_cluster_d = '0;
          idx_d          = '0;
          // Sink and non-forwarding requests pass through SCAN for one
          // cycle without evaluating, so done lands on the first edge after
          // acceptance while busy covers both cycles.
          bypass_d       = iam_sink || !iam_forwarding;
          state_d        = SCAN;
        end
      end
      SCAN: begin
        if (bypass_q) begin
          state_d = DONE;
        end else begin
          if (eligible && better) begin
            found_d        = 1'b1;
            next_hop_id_d  = cur_id;
            best_cost_d    = cand_total;
            best_index_d   = idx_q;
            best_cluster_d = cur_cluster;
          end
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any request immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      bypass_q       <= 1'b0;
      found_q        <= 1'b0;
      local_sink_q   <= 1'b0;
      next_hop_id_q  <= '0;
      best_cost_q    <= COST_INF;
      best_index_q   <= '0;
      best_cluster_q <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      bypass_q       <= bypass_d;
      found_q        <= found_d;
      local_sink_q   <= local_sink_d;
      next_hop_id_q  <= next_hop_id_d;
      best_cost_q    <= best_cost_d;
      best_index_q   <= best_index_d;
      best_cluster_q <= best_cluster_d;
    end
  end

  assign busy        = (state_q == SCAN) || (state_q == DONE);
  assign done        = (state_q == DONE);
  assign found       = found_q;
  assign local_sink  = local_sink_q;
  assign next_hop_id = next_hop_id_q;
  assign best_cost   = best_cost_q;
  assign best_index  = best_index_q;

endmodule

// File: tb/tb_next_hop_selector.sv
// Table-driven bench for next_hop_selector plus hand-written reset and
// start-while-busy sequences.
module tb_next_hop_selector;

  localparam int N  = 10;
  localparam int IW = 5;
  localparam int CW = 8;
  localparam int XW = 4;

  logic            clock;
  logic            reset;
  logic            start;
  logic            iam_sink;
  logic            iam_forwarding;
  logic [IW-1:0]   my_node_id;
  logic [IW-1:0]   my_cluster_id;
  logic [N*IW-1:0] neighbor_ids;
  logic [N*IW-1:0] neighbor_clusters;
  logic [N*CW-1:0] neighbor_costs;
  logic [N-1:0]    neighbor_valid;
  logic            busy;
  logic            done;
  logic            found;
  logic            local_sink;
  logic [IW-1:0]   next_hop_id;
  logic [CW-1:0]   best_cost;
  logic [XW-1:0]   best_index;

  next_hop_selector #(
    .NUM_NEIGHBORS(N), .ID_W(IW), .COST_W(CW), .IDX_W(XW)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .iam_sink(iam_sink), .iam_forwarding(iam_forwarding),
    .my_node_id(my_node_id), .my_cluster_id(my_cluster_id),
    .neighbor_ids(neighbor_ids), .neighbor_clusters(neighbor_clusters),
    .neighbor_costs(neighbor_costs), .neighbor_valid(neighbor_valid),
    .busy(busy), .done(done), .found(found), .local_sink(local_sink),
    .next_hop_id(next_hop_id), .best_cost(best_cost), .best_index(best_index)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [N*IW-1:0] ids;
    logic [N*IW-1:0] clus;
    logic [N*CW-1:0] costs;
    logic [N-1:0]    valid;
    logic [IW-1:0]   my_id;
    logic [IW-1:0]   my_cl;
    logic            sink;
    logic            fwd;
    int              mask;      // bit k set: start driven high across edge E(k)
    int              exp_done;  // edge index after E0 at which done is seen
    logic            exp_found;
    logic            exp_ls;
    logic [IW-1:0]   exp_hop;
    logic [CW-1:0]   exp_cost;
    logic [XW-1:0]   exp_idx;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t basic_vec();
    vec_t v;
    int c[10] = '{9, 7, 5, 5, 8, 12, 6, 9, 10, 11};
    for (int i = 0; i < N; i++) begin
      v.ids[IW*i +: IW]   = IW'(i);
      v.clus[IW*i +: IW]  = 5'd7;
      v.costs[CW*i +: CW] = CW'(c[i]);
    end
    v.valid     = '1;
    v.my_id     = 5'd31;
    v.my_cl     = 5'd3;
    v.sink      = 1'b0;
    v.fwd       = 1'b1;
    v.mask      = 0;
    v.exp_done  = 10;
    v.exp_found = 1'b1;
    v.exp_ls    = 1'b0;
    v.exp_hop   = 5'd2;
    v.exp_cost  = 8'd6;
    v.exp_idx   = 4'd2;
    return v;
  endfunction

  task automatic drive_tables(input vec_t v);
    neighbor_ids      = v.ids;
    neighbor_clusters = v.clus;
    neighbor_costs    = v.costs;
    neighbor_valid    = v.valid;
    my_node_id        = v.my_id;
    my_cluster_id     = v.my_cl;
    iam_sink          = v.sink;
    iam_forwarding    = v.fwd;
  endtask

  // Accept one request, watch a bounded window of edges, check the result.
  task automatic run_vec(input vec_t v, input int num);
    int            done_at;
    int            dones;
    logic          s_found;
    logic          s_ls;
    logic [IW-1:0] s_hop;
    logic [CW-1:0] s_cost;
    logic [XW-1:0] s_idx;
    string         tag;
    tag = $sformatf("vec%0d", num);
    drive_tables(v);
    start = 1'b1;
    @(posedge clock);
    #1;
    chk({tag, " busy@E0"}, 32'(busy), 32'd1);
    done_at = -1;
    dones   = 0;
    s_found = 1'b0; s_ls = 1'b0; s_hop = '0; s_cost = '0; s_idx = '0;
    for (int k = 1; k <= 14; k++) begin
      start = v.mask[k];
      @(posedge clock);
      #1;
      if (done) begin
        dones++;
        if (done_at < 0) begin
          done_at = k;
          s_found = found; s_ls = local_sink; s_hop = next_hop_id;
          s_cost = best_cost; s_idx = best_index;
        end
      end
    end
    start = 1'b0;
    chk({tag, " done_edge"}, 32'(done_at), 32'(v.exp_done));
    chk({tag, " done_count"}, 32'(dones), 32'd1);
    chk({tag, " found"}, 32'(s_found), 32'(v.exp_found));
    chk({tag, " local_sink"}, 32'(s_ls), 32'(v.exp_ls));
    chk({tag, " next_hop_id"}, 32'(s_hop), 32'(v.exp_hop));
    chk({tag, " best_cost"}, 32'(s_cost), 32'(v.exp_cost));
    chk({tag, " best_index"}, 32'(s_idx), 32'(v.exp_idx));
    chk({tag, " busy_after"}, 32'(busy), 32'd0);
    chk({tag, " held_index"}, 32'(best_index), 32'(v.exp_idx));
    $display("[TB] vec%0d done_edge=%0d found=%0b local_sink=%0b hop=%0d cost=%0d index=%0d",
             num, done_at, s_found, s_ls, s_hop, s_cost, s_idx);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " found"}, 32'(found), 32'd0);
    chk({tag, " local_sink"}, 32'(local_sink), 32'd0);
    chk({tag, " next_hop_id"}, 32'(next_hop_id), 32'd0);
    chk({tag, " best_cost"}, 32'(best_cost), 32'hFF);
    chk({tag, " best_index"}, 32'(best_index), 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    int late_dones;

    // Vector table.
    vecs[0] = basic_vec();
    // Sink shortcut.
    vecs[1] = basic_vec();
    vecs[1].sink = 1'b1;
    vecs[1].exp_done = 1; vecs[1].exp_found = 1'b0; vecs[1].exp_ls = 1'b1;
    vecs[1].exp_hop = 5'd0; vecs[1].exp_cost = 8'hFF; vecs[1].exp_idx = 4'd0;
    // Normal scan after a sink result clears local_sink.
    vecs[2] = basic_vec();
    // Not forwarding.
    vecs[3] = basic_vec();
    vecs[3].fwd = 1'b0;
    vecs[3].exp_done = 1; vecs[3].exp_found = 1'b0; vecs[3].exp_ls = 1'b0;
    vecs[3].exp_hop = 5'd0; vecs[3].exp_cost = 8'hFF; vecs[3].exp_idx = 4'd0;
    // Cluster tie-break: foreign cluster replaces own-cluster best.
    vecs[4] = basic_vec();
    for (int i = 0; i < N; i++) vecs[4].costs[CW*i +: CW] = 8'd20;
    vecs[4].costs[CW*3 +: CW] = 8'd4;
    vecs[4].clus[IW*3 +: IW]  = 5'd3;
    vecs[4].costs[CW*6 +: CW] = 8'd4;
    vecs[4].clus[IW*6 +: IW]  = 5'd9;
    vecs[4].exp_hop = 5'd6; vecs[4].exp_cost = 8'd5; vecs[4].exp_idx = 4'd6;
    // Same tie, both in own cluster: lower index kept.
    vecs[5] = vecs[4];
    vecs[5].clus[IW*6 +: IW] = 5'd3;
    vecs[5].exp_hop = 5'd3; vecs[5].exp_idx = 4'd3;
    // No eligible neighbour.
    vecs[6] = basic_vec();
    vecs[6].valid = 10'b11111_00000;
    for (int i = 5; i <= 8; i++) vecs[6].costs[CW*i +: CW] = 8'hFF;
    vecs[6].ids[IW*9 +: IW] = 5'd31;
    vecs[6].exp_found = 1'b0; vecs[6].exp_hop = 5'd0;
    vecs[6].exp_cost = 8'hFF; vecs[6].exp_idx = 4'd0;
    // Best entry is the last one scanned.
    vecs[7] = basic_vec();
    for (int i = 0; i < N; i++) vecs[7].costs[CW*i +: CW] = 8'd20;
    vecs[7].costs[CW*9 +: CW] = 8'd0;
    vecs[7].exp_hop = 5'd9; vecs[7].exp_cost = 8'd1; vecs[7].exp_idx = 4'd9;
    // Largest finite cost: total becomes all ones but is still found.
    vecs[8] = basic_vec();
    vecs[8].valid = 10'b00000_10000;
    vecs[8].costs[CW*4 +: CW] = 8'hFE;
    vecs[8].exp_hop = 5'd4; vecs[8].exp_cost = 8'hFF; vecs[8].exp_idx = 4'd4;
    // Start pulses at E3 and E7 are ignored.
    vecs[9] = basic_vec();
    vecs[9].mask = (1 << 3) | (1 << 7);

    // Reset state.
    reset = 1'b1;
    start = 1'b0;
    drive_tables(basic_vec());
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk_reset_values("reset");
    $display("[TB] reset state checked");

    @(posedge clock);
    #1;
    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset in the middle of a basic scan.
    drive_tables(basic_vec());
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_values("midreset");
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    late_dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clock);
      #1;
      if (done) late_dones++;
    end
    chk("midreset no_done", 32'(late_dones), 32'd0);
    $display("[TB] mid-scan reset checked, stray done pulses=%0d", late_dones);
    run_vec(vecs[0], 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/next_hop_selector.md
# next_hop_selector

Routing stage that runs after the sink and forwarding checks in the cost-evaluation path. When started, it scans the node's neighbour table one entry per clock and selects the cheapest next hop toward a sink. Neighbours in another cluster win cost ties. It returns the chosen neighbour ID, path cost and table index with a one-cycle `done` pulse. If the node is itself a sink, or is not forwarding, it finishes at once without scanning.

## Interface
- `NUM_NEIGHBORS`, default 10: number of table entries scanned.
- `ID_W`, default 5: width of node and cluster IDs.
- `COST_W`, default 8: width of a cost. The all-ones value means unreachable.
- `IDX_W`, default 4: index width. Must satisfy 2^IDX_W ≥ NUM_NEIGHBORS.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: request a selection. Sampled only in IDLE.
- `iam_sink` in 1: node is a sink. Latched when `start` is accepted.
- `iam_forwarding` in 1: node forwards traffic. Latched when `start` is accepted.
- `my_node_id` in ID_W: own node ID, used to exclude self.
- `my_cluster_id` in ID_W: own cluster ID.
- `neighbor_ids` in NUM_NEIGHBORS*ID_W: flattened table. Entry i is at `[ID_W*i +: ID_W]`.
- `neighbor_clusters` in NUM_NEIGHBORS*ID_W: flattened table, same packing as `neighbor_ids`.
- `neighbor_costs` in NUM_NEIGHBORS*COST_W: flattened neighbour-to-sink costs.
- `neighbor_valid` in NUM_NEIGHBORS: bit i set means entry i is populated.
- `busy` out 1: high in SCAN and DONE.
- `done` out 1: one-cycle pulse when the result is valid.
- `found` out 1: an eligible next hop exists.
- `local_sink` out 1: the result is "deliver locally".
- `next_hop_id` out ID_W: selected neighbour ID.
- `best_cost` out COST_W: selected path cost, equal to neighbour cost + 1.
- `best_index` out IDX_W: table index of the selected entry.

## Operation
- Reset values:
  - `busy`, `done`, `found`, `local_sink`: 0.
  - `next_hop_id`, `best_index`: 0.
  - `best_cost`: all ones.
  - State: IDLE. Index counter: 0.
- States are IDLE, SCAN and DONE.
- IDLE:
  - With `start`=1, latch the `iam_sink` and `iam_forwarding` flags.
  - Clear `found` and `local_sink`, set `best_cost` to all ones, and clear `next_hop_id` and `best_index`.
  - If `iam_sink`=1: set `local_sink`=1 and go to DONE.
  - Else if `iam_forwarding`=0: go to DONE with `found`=0.
  - Else: set index to 0 and go to SCAN.
- SCAN: evaluate entry `idx` on each edge.
  - Eligible means: valid bit set, ID ≠ `my_node_id`, and cost ≠ all ones.
  - Candidate total = cost + 1. This fits in COST_W bits because all-ones is excluded.
  - A candidate replaces the current best when either:
    - nothing has been found yet; or
    - total < `best_cost`; or
    - total = `best_cost`, the candidate's cluster ≠ `my_cluster_id`, and the current best's cluster = `my_cluster_id`.
  - On any other tie the lower index is kept.
  - Track the best entry's cluster in an internal register.
  - On replacement: set `found`=1 and update `next_hop_id`, `best_cost` and `best_index`.
  - When `idx` = NUM_NEIGHBORS-1, go to DONE. Otherwise increment `idx`.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Held outputs (`found`, `local_sink`, `next_hop_id`, `best_cost`, `best_index`) keep their values until the next accepted `start`.
- The block does not latch the tables. The upstream stage must hold `neighbor_*` and `my_*` stable while `busy`=1.
- `start` asserted while `busy`=1 is ignored. It is not queued.

## Timing
- Call the edge that accepts `start` E0.
- Scan path:
  - Edges E1..E(N) each evaluate one entry, with entry 0 at E1.
  - E(N) moves the FSM to DONE, so `done` is high from E(N) to E(N+1).
  - `busy` goes high at E0 and low at E(N+1).
- With N = 10, `done` is high 10 cycles after the start edge.
- Sink or no-forward path: `done` is high from E1 to E2, and `busy` from E0 to E2.
- `start` may be held high. After `done`, the next accepted start is no earlier than the IDLE cycle that follows.
- `reset` during SCAN or DONE:
  - Returns to IDLE immediately and restores all reset values.
  - No `done` pulse is produced for the aborted request.
- Result outputs are registered and glitch-free. They change only on accepting edges or scan edges.

## Test plan
- **Basic minimum.**
  - Setup: N = 10, all entries valid, clusters all 7, `my_cluster_id`=3, `my_node_id`=31, IDs = index, costs {9,7,5,5,8,12,6,9,10,11}, `iam_forwarding`=1.
  - Required: `done` at E10, `found`=1, `next_hop_id`=2, `best_index`=2, `best_cost`=6.
- **Cluster tie-break.**
  - Setup: entry 3 cost 4 in cluster 3 (own), entry 6 cost 4 in cluster 9, all others cost 20.
  - Required: `best_index`=6, `best_cost`=5.
  - Repeat with entry 6 also in cluster 3. Required: `best_index`=3.
- **Sink shortcut.**
  - Stimulus: `iam_sink`=1, then `start`.
  - Required: `done` at E1, `local_sink`=1, `found`=0, `best_cost`=8'hFF.
- **No eligible neighbour.**
  - Setup: entries 0–4 invalid, entries 5–8 cost 8'hFF, entry 9 ID = `my_node_id`.
  - Required: `done` at E10, `found`=0, `next_hop_id`=0, `best_index`=0, `best_cost`=8'hFF.
- **Reset mid-scan.**
  - Stimulus: assert `reset` after E4 of the basic test.
  - Required: `busy`=0 immediately and no `done`. A fresh `start` reproduces the basic-test result.
- **Start while busy.**
  - Stimulus: pulse `start` at E3 and E7 of a scan.
  - Required: exactly one `done`, at E10, and results identical to the basic test.
